dmem_ctrl: RTL and testbench

// - Data-memory controller consuming mem_request_t from the core MEMORY stage.
// - Returns mem_response_t to the same stage.
// - Owns the simulation data SRAM (MEM_SIZE bytes).
// - Performs byte/half/word loads and stores: lane steering, sign/zero extension, misalignment check.
// - Performs word fetch-and-add atomics (MEM_ATOMIC) as a locked read-modify-write.

---
 rtl/dmem_ctrl_pkg.sv | 77 +++++++
 rtl/dmem_sram.sv | 25 ++
 rtl/dmem_ctrl.sv | 146 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and helpers for the data-memory controller.
// Request/response bundles, FSM states, lane steering functions.
package dmem_ctrl_pkg;

   localparam int MEM_SIZE       = 65536;
   localparam int MEM_ADDR_WIDTH = 16;
   localparam int DATA_WIDTH     = 32;

   typedef enum logic [1:0] {
      MEM_NONE,
      MEM_LOAD,
      MEM_STORE,
      MEM_ATOMIC
   } mem_op_t;

   typedef enum logic [1:0] {
      MEM_BYTE,
      MEM_HALF,
      MEM_WORD
   } mem_size_t;

   typedef enum logic [1:0] {
      DM_IDLE,
      DM_RD,
      DM_AWR,
      DM_RESP
   } dmem_state_t;

   typedef struct packed {
      logic                  valid;
      mem_op_t               op;
      mem_size_t             size;
      logic                  sign_extend;
      logic [31:0]           addr;
      logic [DATA_WIDTH-1:0] wdata;
   } mem_request_t;

   typedef struct packed {
      logic                  valid;
      logic                  ready;
      logic [DATA_WIDTH-1:0] rdata;
   } mem_response_t;

   function automatic logic [3:0] byte_enable(
      mem_size_t size, logic [1:0] off);
      case (size)
         MEM_BYTE: return 4'b0001 << off;
         MEM_HALF: return 4'b0011 << off;
         default:  return 4'b1111;
      endcase
   endfunction

   function automatic logic [DATA_WIDTH-1:0] load_extract(
      logic [31:0] word, mem_size_t size,
      logic [1:0] off, logic sign);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (size)
         MEM_BYTE:
            return {{24{sign & sh[7]}}, sh[7:0]};
         MEM_HALF:
            return {{16{sign & sh[15]}}, sh[15:0]};
         default:
            return sh;
      endcase
   endfunction

   function automatic logic is_misaligned(
      mem_size_t size, logic [1:0] off);
      case (size)
         MEM_BYTE: return 1'b0;
         MEM_HALF: return off[0];
         default:  return off != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/dmem_sram.sv
// Word-organised data SRAM with per-byte write enables.
// Registered read; same-address write+read returns the old word.
module dmem_sram #(
   parameter int WORDS = 16384,
   parameter int IW    = 14
) (
   input  logic          clk,
   input  logic [IW-1:0] addr,
   input  logic [3:0]    we,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [WORDS];

   always_ff @(posedge clk) begin
      rdata <= mem[addr];
      for (int i = 0; i < 4; i++) begin
         if (we[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: loads, stores and fetch-and-add
// atomics against a private SRAM, one request in flight.
module dmem_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int MEM_BYTES = MEM_SIZE,
   parameter int AW        = MEM_ADDR_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   input  mem_request_t  req_i,
   output logic          req_ready_o,
   output mem_response_t resp_o,
   output logic          resp_err_o
);

   dmem_state_t state;

   mem_op_t     lat_op;
   mem_size_t   lat_size;
   logic        lat_sext;
   logic [AW-1:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [31:0] old_word;

   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   logic [AW-3:0] sram_addr;
   logic [3:0]    sram_we;
   logic [31:0]   sram_wdata;
   logic [31:0]   sram_rdata;

   logic      accept;
   mem_size_t eff_size;
   logic      misaligned;
   logic      bad_access;
   logic      store_ok;
   logic      unused_addr_hi;

   assign unused_addr_hi = ^req_i.addr[31:AW];

   assign accept   = (state == DM_IDLE) && req_i.valid;
   // atomics always operate on a full word
   assign eff_size = (req_i.op == MEM_ATOMIC) ? MEM_WORD
                                              : req_i.size;
   assign misaligned = is_misaligned(eff_size,
                                     req_i.addr[1:0]);
   assign bad_access = misaligned
                    && (req_i.op != MEM_NONE);
   assign store_ok = accept && !bad_access
                  && (req_i.op == MEM_STORE);

   always_comb begin
      sram_addr  = lat_addr[AW-1:2];
      sram_we    = 4'h0;
      sram_wdata = old_word + lat_wdata;
      if (state == DM_IDLE) begin
         sram_addr = req_i.addr[AW-1:2];
         case (req_i.size)
            MEM_BYTE: sram_wdata = {4{req_i.wdata[7:0]}};
            MEM_HALF: sram_wdata = {2{req_i.wdata[15:0]}};
            default:  sram_wdata = req_i.wdata;
         endcase
         if (store_ok && !rst) begin
            sram_we = byte_enable(req_i.size,
                                  req_i.addr[1:0]);
         end
      end else if (state == DM_AWR && !rst) begin
         sram_we = 4'hF;
      end
   end

   dmem_sram #(
      .WORDS (MEM_BYTES / 4),
      .IW    (AW - 2)
   ) u_sram (
      .clk   (clk),
      .addr  (sram_addr),
      .we    (sram_we),
      .wdata (sram_wdata),
      .rdata (sram_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= DM_IDLE;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            DM_IDLE: begin
               resp_valid <= 1'b0;
               if (req_i.valid) begin
                  lat_op    <= req_i.op;
                  lat_size  <= eff_size;
                  lat_sext  <= req_i.sign_extend;
                  lat_addr  <= req_i.addr[AW-1:0];
                  lat_wdata <= req_i.wdata;
                  if (!bad_access &&
                      (req_i.op == MEM_LOAD ||
                       req_i.op == MEM_ATOMIC)) begin
                     state <= DM_RD;
                  end else begin
                     state      <= DM_RESP;
                     resp_valid <= 1'b1;
                     resp_rdata <= '0;
                     resp_err   <= bad_access;
                  end
               end
            end
            DM_RD: begin
               if (lat_op == MEM_ATOMIC) begin
                  old_word <= sram_rdata;
                  state    <= DM_AWR;
               end else begin
                  resp_rdata <= load_extract(sram_rdata,
                     lat_size, lat_addr[1:0], lat_sext);
                  resp_err   <= 1'b0;
                  resp_valid <= 1'b1;
                  state      <= DM_RESP;
               end
            end
            DM_AWR: begin
               resp_rdata <= old_word;
               resp_err   <= 1'b0;
               resp_valid <= 1'b1;
               state      <= DM_RESP;
            end
            default: begin
               resp_valid <= 1'b0;
               state      <= DM_IDLE;
            end
         endcase
      end
   end

   assign req_ready_o  = (state == DM_IDLE);
   assign resp_o.valid = resp_valid;
   assign resp_o.ready = req_ready_o;
   assign resp_o.rdata = resp_rdata;
   assign resp_err_o   = resp_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomised bench for dmem_ctrl with a byte-array memory model
// and a per-cycle compare process.
module tb_dmem_ctrl;
   import dmem_ctrl_pkg::*;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   mem_request_t  req;
   logic          req_ready;
   mem_response_t resp;
   logic          resp_err;

   always #5 clk = ~clk;

   dmem_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .req_i       (req),
      .req_ready_o (req_ready),
      .resp_o      (resp),
      .resp_err_o  (resp_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(string name, logic [31:0] act,
                      logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h",
                  name, act, exp);
      end
   endtask

   // reference model state
   bit [7:0]    mm [MEM_SIZE];
   int          cyc = 0;
   bit          pend = 0;
   int          acc_c = 0;
   int          exp_c = 0;
   logic [31:0] exp_rd = 0;
   bit          exp_err = 0;
   bit          has_wr = 0;
   int          wr_a = 0;
   logic [31:0] wr_v = 0;
   logic [31:0] model_rdata = 0;
   int          resp_count = 0;
   logic [31:0] last_rdata = 0;
   logic        last_err = 0;
   int          last_lat = 0;

   always @(posedge clk) cyc++;

   function automatic logic [31:0] rd_bytes(int a, int n);
      logic [31:0] v = 0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mm[a + i];
      return v;
   endfunction

   always @(negedge clk) begin
      bit ev;
      bit busy;
      int a;
      int n;
      logic [31:0] v;
      if (rst) begin
         pend        = 0;
         model_rdata = 0;
      end else begin
         ev   = pend && (cyc == exp_c);
         busy = pend && (cyc > acc_c);
         chk("ready", {31'b0, req_ready}, {31'b0, !busy});
         chk("resp_ready", {31'b0, resp.ready},
             {31'b0, !busy});
         chk("resp_valid", {31'b0, resp.valid},
             {31'b0, ev});
         if (resp.valid && ev) begin
            chk("rdata", resp.rdata, exp_rd);
            chk("err", {31'b0, resp_err}, {31'b0, exp_err});
            if (has_wr)
               for (int i = 0; i < 4; i++)
                  mm[wr_a + i] = wr_v[8*i +: 8];
            model_rdata = exp_rd;
            pend        = 0;
            resp_count++;
            last_rdata  = resp.rdata;
            last_err    = resp_err;
            last_lat    = cyc - acc_c;
         end else begin
            if (pend && cyc >= exp_c) pend = 0;
            chk("rdata_hold", resp.rdata, model_rdata);
         end
         if (req.valid && req_ready) begin
            a = int'(req.addr[15:0]);
            if (req.op == MEM_ATOMIC) n = 4;
            else if (req.size == MEM_BYTE) n = 1;
            else if (req.size == MEM_HALF) n = 2;
            else n = 4;
            acc_c   = cyc;
            pend    = 1;
            has_wr  = 0;
            exp_rd  = 0;
            exp_err = 0;
            exp_c   = cyc + 1;
            if (req.op == MEM_NONE) begin
            end else if (a % n != 0) begin
               exp_err = 1;
            end else if (req.op == MEM_STORE) begin
               for (int i = 0; i < n; i++)
                  mm[a + i] = req.wdata[8*i +: 8];
            end else if (req.op == MEM_LOAD) begin
               v = rd_bytes(a, n);
               if (req.sign_extend && n < 4 && v[8*n-1])
                  for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
               exp_rd = v;
               exp_c  = cyc + 2;
            end else begin
               exp_rd = rd_bytes(a, 4);
               has_wr = 1;
               wr_a   = a;
               wr_v   = exp_rd + req.wdata;
               exp_c  = cyc + 3;
            end
         end
      end
   end

   // leaves req.valid high; caller decides what comes next
   task automatic send(mem_op_t op, mem_size_t sz, bit sx,
                       logic [31:0] ad, logic [31:0] wd);
      req.valid       = 1'b1;
      req.op          = op;
      req.size        = sz;
      req.sign_extend = sx;
      req.addr        = ad;
      req.wdata       = wd;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (req_ready) begin
            @(posedge clk);
            #1;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL accept_timeout got busy expected ready");
   endtask

   task automatic wait_resp(int target);
      for (int t = 0; t < 12; t++) begin
         if (resp_count >= target) return;
         @(posedge clk);
         #1;
      end
      checks++;
      errors++;
      $display("FAIL resp_timeout got %0d expected %0d",
               resp_count, target);
   endtask

   task automatic xact(mem_op_t op, mem_size_t sz, bit sx,
                       logic [31:0] ad, logic [31:0] wd);
      int b;
      b = resp_count;
      send(op, sz, sx, ad, wd);
      req.valid = 1'b0;
      wait_resp(b + 1);
   endtask

   initial begin
      int b;
      req = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_valid", {31'b0, resp.valid}, 32'd0);
      chk("rst_rdata", resp.rdata, 32'd0);
      chk("rst_err", {31'b0, resp_err}, 32'd0);
      @(posedge clk);
      #1;

      for (int w = 0; w < 64; w++)
         xact(MEM_STORE, MEM_WORD, 0, 32'(w * 4), 0);
      for (int w = 1; w <= 5; w++)
         xact(MEM_STORE, MEM_WORD, 0, 32'(w * 256), 0);

      xact(MEM_STORE, MEM_WORD, 0, 32'h100, 32'hDEADBEEF);
      chk("sw_lat", last_lat, 1);
      xact(MEM_LOAD, MEM_WORD, 0, 32'h100, 0);
      chk("lw_data", last_rdata, 32'hDEADBEEF);
      chk("lw_err", {31'b0, last_err}, 0);
      chk("lw_lat", last_lat, 2);

      xact(MEM_STORE, MEM_BYTE, 0, 32'h203, 32'h80);
      xact(MEM_LOAD, MEM_BYTE, 1, 32'h203, 0);
      chk("lb", last_rdata, 32'hFFFFFF80);
      xact(MEM_LOAD, MEM_BYTE, 0, 32'h203, 0);
      chk("lbu", last_rdata, 32'h00000080);
      xact(MEM_LOAD, MEM_WORD, 0, 32'h200, 0);
      chk("lw_byte", last_rdata, 32'h80000000);

      xact(MEM_STORE, MEM_HALF, 0, 32'h302, 32'h8001);
      xact(MEM_LOAD, MEM_HALF, 1, 32'h302, 0);
      chk("lh", last_rdata, 32'hFFFF8001);
      xact(MEM_LOAD, MEM_HALF, 0, 32'h302, 0);
      chk("lhu", last_rdata, 32'h00008001);
      xact(MEM_STORE, MEM_HALF, 0, 32'h301, 32'h5555);
      xact(MEM_LOAD, MEM_HALF, 1, 32'h301, 0);
      chk("lh_mis_err", {31'b0, last_err}, 1);
      chk("lh_mis_data", last_rdata, 0);
      chk("lh_mis_lat", last_lat, 1);
      xact(MEM_LOAD, MEM_WORD, 0, 32'h300, 0);
      chk("mis_unchanged", last_rdata, 32'h80010000);

      xact(MEM_STORE, MEM_WORD, 0, 32'h400, 32'hFFFFFFFE);
      xact(MEM_ATOMIC, MEM_BYTE, 0, 32'h400, 5);
      chk("amo_old", last_rdata, 32'hFFFFFFFE);
      chk("amo_lat", last_lat, 3);
      xact(MEM_LOAD, MEM_WORD, 0, 32'h400, 0);
      chk("amo_new", last_rdata, 32'h00000003);

      xact(MEM_STORE, MEM_WORD, 0, 32'h0001_0004, 32'h12345678);
      xact(MEM_LOAD, MEM_WORD, 0, 32'h0000_0004, 0);
      chk("alias", last_rdata, 32'h12345678);

      b = resp_count;
      send(MEM_LOAD, MEM_WORD, 0, 32'h100, 0);
      send(MEM_STORE, MEM_HALF, 0, 32'h10, 32'hABCD);
      send(MEM_ATOMIC, MEM_WORD, 0, 32'h100, 1);
      req.valid = 1'b0;
      wait_resp(b + 3);
      chk("b2b_count", resp_count - b, 3);
      chk("b2b_last", last_rdata, 32'hDEADBEEF);

      xact(MEM_STORE, MEM_WORD, 0, 32'h500, 7);
      b = resp_count;
      send(MEM_ATOMIC, MEM_WORD, 0, 32'h500, 1);
      req.valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("amo_rst_ready", {31'b0, req_ready}, 1);
      chk("amo_rst_valid", {31'b0, resp.valid}, 0);
      repeat (5) @(posedge clk);
      #1;
      chk("amo_rst_noresp", resp_count, b);
      xact(MEM_LOAD, MEM_WORD, 0, 32'h500, 0);
      chk("amo_rst_mem", last_rdata, 7);

      repeat (400) begin
         send(mem_op_t'($urandom_range(0, 3)),
              mem_size_t'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)),
              ($urandom & 32'hFFFF_0000)
                | 32'($urandom_range(0, 255)),
              $urandom);
         if ($urandom_range(0, 3) == 0) begin
            req.valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      req.valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
